// File: rtl/hba_serial_host_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : hba_serial_host_if
// Description : Request/response bundle between a requester and the serial
//               host (one register read/write per transaction).
// Revision    : 1.0 - initial release
// ============================================================================
interface hba_serial_host_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [3:0] cmd_periph;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       busy;

  // Requester side
  modport master (
    output cmd_valid, cmd_rw, cmd_periph, cmd_reg, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy
  );

  // Serial host side
  modport slave (
    input  cmd_valid, cmd_rw, cmd_periph, cmd_reg, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy
  );
endinterface
`default_nettype wire

// File: rtl/hba_serial_host.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : hba_serial_host
// Description : Initiator end of the serial_fpga command protocol. Sends one
//               register read/write as 8N1 bytes on txd and, for reads,
//               captures the single reply byte from rxd (with timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module hba_serial_host #(
  parameter int unsigned CLK_FREQUENCY     = 50_000_000,
  parameter int unsigned BAUD              = 115_200,
  parameter int unsigned PERIPH_ADDR_WIDTH = 4,
  parameter int unsigned REG_ADDR_WIDTH    = 8,
  parameter int unsigned DBUS_WIDTH        = 8,
  parameter int unsigned TIMEOUT_BITS      = 100
) (
  input  logic               clk,
  input  logic               reset,
  output logic               txd,
  input  logic               rxd,
  hba_serial_host_if.slave   bus
);

  localparam int unsigned c_cpb   = CLK_FREQUENCY / BAUD;
  localparam int unsigned c_half  = c_cpb / 2;
  localparam int unsigned c_tmo   = TIMEOUT_BITS * c_cpb;
  localparam int unsigned c_cnt_w = $clog2(c_cpb);
  localparam int unsigned c_tmo_w = $clog2(c_tmo);

  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_cpb - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last  = c_tmo_w'(c_tmo - 1);

  // Bit slot 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
  localparam logic [3:0] c_stop_slot = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX      = 3'd1,
    S_RX_WAIT = 3'd2,
    S_RX_DATA = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic                           txd_q, txd_d;
  logic                           cmd_ready_q, cmd_ready_d;
  logic                           rsp_valid_q, rsp_valid_d;
  logic [DBUS_WIDTH-1:0]          rsp_rdata_q, rsp_rdata_d;
  logic                           rsp_error_q, rsp_error_d;
  logic [c_cnt_w-1:0]             clk_cnt_q, clk_cnt_d;
  logic [3:0]                     bit_q, bit_d;
  logic [1:0]                     byte_q, byte_d;
  logic [c_tmo_w-1:0]             tmo_q, tmo_d;
  logic [DBUS_WIDTH-1:0]          rx_shift_q, rx_shift_d;
  logic                           rw_q, rw_d;
  logic [PERIPH_ADDR_WIDTH-1:0]   periph_q, periph_d;
  logic [REG_ADDR_WIDTH-1:0]      reg_q, reg_d;
  logic [DBUS_WIDTH-1:0]          wdata_q, wdata_d;
  logic                           rxd_meta_q, rxd_meta_d;
  logic                           rxd_sync_q, rxd_sync_d;
  logic                           rxd_prev_q, rxd_prev_d;

  logic [7:0]                     w_tx_byte;
  logic [1:0]                     w_last_byte;
  logic                           w_fall;

  assign txd           = txd_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = ~cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

  // Start-bit edge on the synchronised receive line.
  assign w_fall      = rxd_prev_q & ~rxd_sync_q;
  // Reads stop after the register byte, writes carry a data byte too.
  assign w_last_byte = rw_q ? 2'd1 : 2'd2;

  // Select the frame byte currently being shifted out.
  always_comb begin
    case (byte_q)
      2'd0:    w_tx_byte = {rw_q, 3'b000, periph_q};
      2'd1:    w_tx_byte = reg_q;
      default: w_tx_byte = wdata_q;
    endcase
  end

  // Next-state logic for the transaction FSM, UART shifters and sync chain.
  always_comb begin
    state_d     = state_q;
    txd_d       = txd_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    clk_cnt_d   = clk_cnt_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    tmo_d       = tmo_q;
    rx_shift_d  = rx_shift_q;
    rw_d        = rw_q;
    periph_d    = periph_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    rxd_meta_d  = rxd;
    rxd_sync_d  = rxd_meta_q;
    rxd_prev_d  = rxd_sync_q;

    case (state_q)
      S_IDLE: begin
        txd_d       = 1'b1;
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          rw_d        = bus.cmd_rw;
          periph_d    = bus.cmd_periph;
          reg_d       = bus.cmd_reg;
          wdata_d     = bus.cmd_wdata;
          cmd_ready_d = 1'b0;
          txd_d       = 1'b0;
          clk_cnt_d   = '0;
          bit_d       = '0;
          byte_d      = '0;
          state_d     = S_TX;
        end
      end

      S_TX: begin
        if (clk_cnt_q == c_bit_last) begin
          clk_cnt_d = '0;
          if (bit_q == c_stop_slot) begin
            if (byte_q == w_last_byte) begin
              txd_d = 1'b1;
              if (rw_q) begin
                tmo_d   = '0;
                state_d = S_RX_WAIT;
              end else begin
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b0;
                state_d     = S_DONE;
              end
            end else begin
              // Next byte's start bit follows the stop bit with no gap.
              byte_d = byte_q + 2'd1;
              bit_d  = '0;
              txd_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            txd_d = (bit_q == 4'd8) ? 1'b1 : w_tx_byte[bit_q[2:0]];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_RX_WAIT: begin
        // A start edge takes priority over a timeout on the same clock.
        if (w_fall) begin
          clk_cnt_d = '0;
          bit_d     = '0;
          state_d   = S_RX_DATA;
        end else if (tmo_q == c_tmo_last) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_RX_DATA: begin
        if (bit_q == 4'd0) begin
          if (clk_cnt_q == c_half_last) begin
            clk_cnt_d = '0;
            if (rxd_sync_q) begin
              // Start bit vanished: a glitch. Resume waiting; timeout keeps its count.
              state_d = S_RX_WAIT;
            end else begin
              bit_d = 4'd1;
            end
          end else begin
            clk_cnt_d = clk_cnt_q + 1'b1;
          end
        end else if (clk_cnt_q == c_bit_last) begin
          clk_cnt_d = '0;
          if (bit_q == c_stop_slot) begin
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
            if (rxd_sync_q) begin
              rsp_rdata_d = rx_shift_q;
              rsp_error_d = 1'b0;
            end else begin
              rsp_error_d = 1'b1;
            end
          end else begin
            rx_shift_d = {rxd_sync_q, rx_shift_q[DBUS_WIDTH-1:1]};
            bit_d      = bit_q + 4'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any frame and forces the line idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      txd_q       <= 1'b1;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      clk_cnt_q   <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      tmo_q       <= '0;
      rx_shift_q  <= '0;
      rw_q        <= 1'b0;
      periph_q    <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rxd_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      txd_q       <= txd_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      tmo_q       <= tmo_d;
      rx_shift_q  <= rx_shift_d;
      rw_q        <= rw_d;
      periph_q    <= periph_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      rxd_meta_q  <= rxd_meta_d;
      rxd_sync_q  <= rxd_sync_d;
      rxd_prev_q  <= rxd_prev_d;
    end
  end

endmodule
`default_nettype wire
